// File: rtl/axi_cnt_master.sv
// axi_cnt_master: AXI traffic generator that writes a running counter into a
// word-indexed register slave, reads it back, compares the two values and
// keeps pass/fail statistics. One transaction in flight at a time.
module axi_cnt_master #(
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [3:0]  AXI_ID    = 4'h1
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        enable_i,
    // write address channel
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    // write data channel
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    // write response channel
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    // read address channel
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    // read data channel
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    // status
    output logic        busy_o,
    output logic [31:0] cnt_o,
    output logic [15:0] pass_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_BRESP, S_RD, S_RDATA, S_CHECK
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              fail_q, fail_d;
    logic              err_q, err_d;

    logic aw_hs, w_hs, wdog_expired;

    assign aw_hs        = awvalid_q & awready_i;
    assign w_hs         = wvalid_q & wready_i;
    assign wdog_expired = (wdog_q == WD_W'(TIMEOUT - 1));

    // Next-state, channel handshakes, watchdog abort and check bookkeeping.
    always_comb begin
        // NOTE: every _d starts as its _q so no branch of the case can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        fail_d     = fail_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    fail_d    = 1'b0;
                    state_d   = S_WR;
                end
            end
            S_WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = S_BRESP;
                end else if (wdog_expired) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    fail_d    = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_BRESP: begin
                if (bvalid_i) begin
                    bready_d = 1'b0;
                    if (bresp_i != 2'b00) begin
                        fail_d  = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD;
                    end
                end else if (wdog_expired) begin
                    bready_d = 1'b0;
                    fail_d   = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_RD: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else if (wdog_expired) begin
                    arvalid_d = 1'b0;
                    fail_d    = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_RDATA: begin
                if (rvalid_i) begin
                    rdata_d  = rdata_i;
                    rready_d = 1'b0;
                    state_d  = S_CHECK;
                end else if (wdog_expired) begin
                    rready_d = 1'b0;
                    fail_d   = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((rdata_q == cnt_q) && !fail_q) begin
                    if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
                end else begin
                    if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    err_d = 1'b1;
                end
                cnt_d   = cnt_q + 32'd1;
                idx_d   = (idx_q == IDX_W'(REG_COUNT - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog restarts whenever the FSM moves; it may wrap harmlessly in IDLE.
        wdog_d = (state_d != state_q) ? '0 : wdog_q + WD_W'(1);
    end

    // State register; asynchronous active-low reset clears the whole block at once.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            wdog_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            wdog_q     <= wdog_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
        end
    end

    // Address and data come straight from idx/cnt, which only change in CHECK,
    // so they are stable for as long as any valid is high.
    assign awid_o     = AXI_ID;
    assign awaddr_o   = 32'(idx_q);
    assign awvalid_o  = awvalid_q;
    assign wid_o      = AXI_ID;
    assign wdata_o    = cnt_q;
    assign wstrb_o    = 4'hF;
    assign wlast_o    = 1'b1;
    assign wvalid_o   = wvalid_q;
    assign bready_o   = bready_q;
    assign arid_o     = AXI_ID;
    assign araddr_o   = 32'(idx_q);
    assign arvalid_o  = arvalid_q;
    assign rready_o   = rready_q;
    assign busy_o     = (state_q != S_IDLE);
    assign cnt_o      = cnt_q;
    assign pass_cnt_o = pass_cnt_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_o      = err_q;

    // Response IDs and rlast carry no information for a single-beat, single-ID master.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bid_i, rid_i, rlast_i};

endmodule

// File: tb/tb_axi_cnt_master.sv
// tb_axi_cnt_master: the bench plays the register slave one transaction at a
// time with randomized wait states and injected faults, and compares the
// master against a counter/modulo reference model of the expected traffic.
module tb_axi_cnt_master;

    localparam int unsigned REG_COUNT = 8;
    localparam int unsigned TIMEOUT   = 64;
    localparam logic [3:0]  AXI_ID    = 4'h1;

    logic        clk, areset, enable_i;
    logic [3:0]  awid_o, wid_o, arid_o, bid_i, rid_i;
    logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i, cnt_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o, arvalid_o, arready_i;
    logic        rlast_i, rvalid_i, rready_o, busy_o, err_o;
    logic [15:0] pass_cnt_o, err_cnt_o;

    axi_cnt_master #(.REG_COUNT(REG_COUNT), .TIMEOUT(TIMEOUT), .AXI_ID(AXI_ID)) dut (
        .clk(clk), .areset(areset), .enable_i(enable_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .busy_o(busy_o), .cnt_o(cnt_o),
        .pass_cnt_o(pass_cnt_o), .err_cnt_o(err_cnt_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Slave register contents and reference model of the master's bookkeeping.
    logic [31:0] mem [REG_COUNT];
    int unsigned exp_cnt, exp_idx, exp_pass, exp_err;
    logic        exp_err_flag;
    int unsigned last_aw_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_cnt = 0; exp_idx = 0; exp_pass = 0; exp_err = 0; exp_err_flag = 1'b0;
    endtask

    // One finished loop: pass or fail, then counter and index advance.
    task automatic model_commit(input bit ok);
        if (ok) exp_pass++;
        else begin
            exp_err++;
            exp_err_flag = 1'b1;
        end
        exp_cnt++;
        exp_idx = (exp_idx + 1) % REG_COUNT;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"},  cnt_o,      exp_cnt);
        check({tag, "_pass"}, pass_cnt_o, exp_pass);
        check({tag, "_err"},  err_cnt_o,  exp_err);
        check({tag, "_errf"}, err_o,      exp_err_flag);
        check({tag, "_busy"}, busy_o,     0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, awvalid_o, 0);
        check({tag, "_wvalid"},  wvalid_o,  0);
        check({tag, "_bready"},  bready_o,  0);
        check({tag, "_arvalid"}, arvalid_o, 0);
        check({tag, "_rready"},  rready_o,  0);
        check({tag, "_busy"},    busy_o,    0);
        check({tag, "_err"},     err_o,     0);
        check({tag, "_cnt"},     cnt_o,     0);
        check({tag, "_pass"},    pass_cnt_o, 0);
        check({tag, "_errcnt"},  err_cnt_o, 0);
        check({tag, "_addr"},    {awaddr_o ^ araddr_o, awaddr_o | araddr_o}, 0);
        check({tag, "_wdata"},   wdata_o,   0);
        check({tag, "_wstrb"},   wstrb_o,   4'hF);
        check({tag, "_ids"},     {awid_o, wid_o, arid_o}, {AXI_ID, AXI_ID, AXI_ID});
    endtask

    // Acts as the slave for one loop, entered and left on a negedge.
    task automatic run_txn(input int aw_dly, input int w_dly, input int b_dly,
                           input int ar_dly, input int r_dly, input logic [1:0] bresp,
                           input bit corrupt, input bit ar_stuck, input bit rst_rdata,
                           input bit drop_en, input int period);
        int n;
        bit aw_ok, w_ok;
        logic [31:0] wa, wd;
        n = 0;
        while (!awvalid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("aw_start", awvalid_o, 1);
        if (!awvalid_o) return;
        if (period > 0) check("aw_period", cyc - last_aw_cyc, period);
        last_aw_cyc = cyc;
        if (drop_en) enable_i = 1'b0;
        check("awaddr", awaddr_o, exp_idx);
        check("wdata",  wdata_o,  exp_cnt);
        check("wstrb_wlast", {wstrb_o, wlast_o}, 5'h1F);

        // Write address and data, each with its own wait.
        aw_ok = 1'b0; w_ok = 1'b0; n = 0; wa = '0; wd = '0;
        while (!(aw_ok && w_ok)) begin
            awready_i = !aw_ok && (n >= aw_dly);
            wready_i  = !w_ok && (n >= w_dly);
            if (aw_ok) check("awvalid_drop", awvalid_o, 0);
            else begin
                check("awvalid_hold", awvalid_o, 1);
                check("awaddr_stable", awaddr_o, exp_idx);
            end
            if (w_ok) check("wvalid_drop", wvalid_o, 0);
            else begin
                check("wvalid_hold", wvalid_o, 1);
                check("wdata_stable", wdata_o, exp_cnt);
            end
            if (awvalid_o && awready_i) begin aw_ok = 1'b1; wa = awaddr_o; end
            if (wvalid_o && wready_i)   begin w_ok = 1'b1;  wd = wdata_o;  end
            @(negedge clk);
            n++;
            if (n > 100) begin
                check("wr_bound", 0, 1);
                awready_i = 1'b0; wready_i = 1'b0;
                return;
            end
        end
        awready_i = 1'b0; wready_i = 1'b0;
        mem[wa % REG_COUNT] = wd;
        check("wr_valids_low", {awvalid_o, wvalid_o}, 0);

        // Write response.
        check("bready", bready_o, 1);
        repeat (b_dly) @(negedge clk);
        check("bready_hold", bready_o, 1);
        bvalid_i = 1'b1; bresp_i = bresp;
        @(negedge clk);
        bvalid_i = 1'b0; bresp_i = 2'b00;
        if (bresp != 2'b00) begin
            check("no_ar", arvalid_o, 0);
            check("bresp_busy", busy_o, 1);
            @(negedge clk);
            check("no_ar_idle", arvalid_o, 0);
            model_commit(1'b0);
            check_status("bresp");
            return;
        end

        // Read address.
        check("arvalid", arvalid_o, 1);
        check("araddr",  araddr_o,  exp_idx);
        if (ar_stuck) begin
            n = 0;
            while (arvalid_o && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("ar_timeout_len", n, TIMEOUT);
            check("ar_drop", {arvalid_o, rready_o}, 0);
            check("timeout_busy", busy_o, 1);
            @(negedge clk);
            model_commit(1'b0);
            check_status("timeout");
            return;
        end
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            check("arvalid_hold", arvalid_o, 1);
            check("araddr_stable", araddr_o, exp_idx);
        end
        arready_i = 1'b1;
        @(negedge clk);
        arready_i = 1'b0;

        // Read data.
        check("rready", {rready_o, arvalid_o}, 2'b10);
        if (rst_rdata) return;
        repeat (r_dly) @(negedge clk);
        check("rready_hold", rready_o, 1);
        rvalid_i = 1'b1;
        rdata_i  = corrupt ? 32'hDEADBEEF : mem[araddr_o % REG_COUNT];
        @(negedge clk);
        rvalid_i = 1'b0;
        check("check_busy", {busy_o, rready_o}, 2'b10);
        @(negedge clk);
        model_commit(!corrupt);
        check_status("done");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int fault;
        areset = 1'b0; enable_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
        bid_i = AXI_ID; rid_i = AXI_ID; bresp_i = 2'b00; bvalid_i = 1'b0;
        rdata_i = '0; rlast_i = 1'b1; rvalid_i = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) mem[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        areset = 1'b1;
        @(negedge clk);

        // Zero-wait slave, eight back-to-back loops covering every register.
        enable_i = 1'b1;
        for (int k = 0; k < 8; k++) run_txn(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, (k > 0) ? 6 : 0);
        check("pass8", pass_cnt_o, 8);
        check("err_none", err_o, 0);

        // AW held off for 5 cycles while W is accepted at once; addr wraps to 0.
        run_txn(5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // Corrupt read data on register 3.
        for (int k = 0; k < 3; k++) run_txn(0, 0, 0, 0, 0, 2'b00, exp_idx == 3, 0, 0, 0, 0);
        check("corrupt_errcnt", err_cnt_o, 1);
        check("corrupt_errf", err_o, 1);
        run_txn(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // Error write response: no read is issued.
        run_txn(1, 2, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0);

        // Read address never accepted: watchdog abort, then the next loop runs.
        run_txn(0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

        // Randomized wait states and faults.
        for (int k = 0; k < 30; k++) begin
            fault = $urandom_range(0, 9);
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    (fault == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    fault == 1, fault == 2, 0, 0, 0);
        end

        // Enable dropped mid-loop: loop completes and the master stays idle.
        run_txn(2, 1, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stay_idle", {awvalid_o, busy_o}, 0);
        end

        // Reset while waiting for read data, then restart from register 0.
        enable_i = 1'b1;
        run_txn(0, 0, 0, 0, 2, 2'b00, 0, 0, 1, 0, 0);
        areset = 1'b0;
        #1;
        check_reset_outputs("rst_rdata");
        model_reset();
        @(negedge clk);
        areset = 1'b1;
        run_txn(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        run_txn(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
